// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if
//   Signal bundle between the three writeback requesters, the register-file
//   write port, the issue stage and the writeback arbiter.
//
//   Handshake (one rule for every requester i): a transfer happens in the
//   cycle where req_vld[i] & req_rdy[i] are both high. req_rdy never depends
//   on anything the requester does in the same cycle except req_vld. While
//   req_vld[i] is high and not granted, the requester holds req_addr/req_data.
//   The requester may drop req_vld without a transfer.
//
//   Signals:
//     req_vld/req_addr/req_data  requester -> arbiter (packed, slot i at i*AW / i*DW)
//     req_rdy                    arbiter -> requester, one-hot grant
//     rf_we/rf_waddr/rf_wdata    arbiter -> register file (registered)
//     iss_vld/iss_addr           issue stage -> arbiter (destination being issued)
//     busy                       arbiter -> issue stage, pending-write scoreboard
//     fwd_*                      bypass port, only when WB_FWD_EN is defined
//
//   Build option: WB_FWD_EN adds fwd_raddr1/fwd_raddr2/fwd_hit1/fwd_hit2/fwd_data.
interface rf_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_vld;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_rdy;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic               iss_vld;
  logic [AW-1:0]      iss_addr;
  logic [31:0]        busy;
`ifdef WB_FWD_EN
  logic [AW-1:0]      fwd_raddr1;
  logic [AW-1:0]      fwd_raddr2;
  logic               fwd_hit1;
  logic               fwd_hit2;
  logic [DW-1:0]      fwd_data;

  modport master (
    output req_vld, req_addr, req_data, iss_vld, iss_addr, fwd_raddr1, fwd_raddr2,
    input  req_rdy, rf_we, rf_waddr, rf_wdata, busy, fwd_hit1, fwd_hit2, fwd_data
  );
  modport slave (
    input  req_vld, req_addr, req_data, iss_vld, iss_addr, fwd_raddr1, fwd_raddr2,
    output req_rdy, rf_we, rf_waddr, rf_wdata, busy, fwd_hit1, fwd_hit2, fwd_data
  );
`else
  modport master (
    output req_vld, req_addr, req_data, iss_vld, iss_addr,
    input  req_rdy, rf_we, rf_waddr, rf_wdata, busy
  );
  modport slave (
    input  req_vld, req_addr, req_data, iss_vld, iss_addr,
    output req_rdy, rf_we, rf_waddr, rf_wdata, busy
  );
`endif
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the single register-file write port among NREQ writeback
//   requesters (0=ALU, 1=load, 2=mul/div) with round-robin arbitration,
//   registers the winning write towards the register file, and keeps a
//   32-entry pending-write scoreboard for the issue stage.
//
//   Ports:
//     clk  posedge clock
//     rst  synchronous, active-high reset
//     bus  rf_wb_arbiter_if.slave (requests, grants, rf write, issue, busy)
//
//   Build option: WB_FWD_EN enables the writeback bypass outputs
//   fwd_hit1/fwd_hit2/fwd_data, compared against fwd_raddr1/fwd_raddr2.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [NREQ-1:0] gnt;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_data;

  logic            rf_we_q;
  logic [AW-1:0]   rf_waddr_q;
  logic [DW-1:0]   rf_wdata_q;
  logic [31:0]     busy_q;
  logic [31:0]     busy_nxt;

  // Round-robin search in two passes: first the indices at or above ptr,
  // then the ones below it. This walks ptr, ptr+1, ... wrapping, using only
  // constant bit selects.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!rst && !gnt_any && (i >= int'(ptr)) && bus.req_vld[i]) begin
        gnt[i]  = 1'b1;
        gnt_idx = PW'(i);
        gnt_any = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!rst && !gnt_any && (i < int'(ptr)) && bus.req_vld[i]) begin
        gnt[i]  = 1'b1;
        gnt_idx = PW'(i);
        gnt_any = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_addr = bus.req_addr[i*AW +: AW];
        gnt_data = bus.req_data[i*DW +: DW];
      end
    end
  end

  // Clear first, then set: an issue to the same register in the grant cycle
  // belongs to a newer producer and must keep the bit set.
  always_comb begin
    busy_nxt = busy_q;
    if (gnt_any && (gnt_addr != '0)) begin
      busy_nxt[gnt_addr] = 1'b0;
    end
    if (bus.iss_vld && (bus.iss_addr != '0)) begin
      busy_nxt[bus.iss_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // A grant to register 0 is consumed (and its address/data captured like
  // any other grant) but never raises rf_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      busy_q <= busy_nxt;
      if (gnt_any) begin
        ptr        <= (gnt_idx == PW'(NREQ - 1)) ? '0 : PW'(gnt_idx + 1'b1);
        rf_we_q    <= (gnt_addr != '0);
        rf_waddr_q <= gnt_addr;
        rf_wdata_q <= gnt_data;
      end else begin
        rf_we_q <= 1'b0;
      end
    end
  end

  assign bus.req_rdy  = gnt;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.busy     = busy_q;

`ifdef WB_FWD_EN
  assign bus.fwd_hit1 = rf_we_q && (rf_waddr_q == bus.fwd_raddr1) && (rf_waddr_q != '0);
  assign bus.fwd_hit2 = rf_we_q && (rf_waddr_q == bus.fwd_raddr2) && (rf_waddr_q != '0);
  assign bus.fwd_data = rf_wdata_q;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter
//   Directed bench for rf_wb_arbiter. A behavioural model (round-robin pick
//   over a rotated index order, a write queue, a busy bit vector) is checked
//   against the DUT on every negedge; the directed sequence adds literal
//   expectations at the interesting points.
//   Build option: WB_FWD_EN also exercises the bypass outputs.
module tb_rf_wb_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int W    = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [31:0]   m_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Index of the first valid requester in the order ptr, ptr+1, ... (mod NREQ);
  // -1 when none is valid.
  function automatic int rr_pick(input logic [NREQ-1:0] vld, input int ptr);
    int i;
    for (int k = 0; k < NREQ; k++) begin
      i = (ptr + k) % NREQ;
      if (((vld >> i) & 1) != 0) return i;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input logic [NREQ-1:0] vld,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    bus.req_vld  = vld;
    bus.req_addr = {a2, a1, a0};
    bus.req_data = {d2, d1, d0};
  endtask

  task automatic set_iss(input logic v, input logic [AW-1:0] a);
    bus.iss_vld  = v;
    bus.iss_addr = a;
  endtask

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [W-1:0] front;
    m_ptr   = 0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_busy  = '0;
    forever begin
      mid();
      g       = rst ? -1 : rr_pick(bus.req_vld, m_ptr);
      exp_rdy = (g < 0) ? '0 : NREQ'(1) << g;
      chk("req_rdy",  bus.req_rdy,  exp_rdy);
      chk("rf_we",    bus.rf_we,    m_we);
      chk("rf_waddr", bus.rf_waddr, m_waddr);
      chk("rf_wdata", bus.rf_wdata, m_wdata);
      chk("busy",     bus.busy,     m_busy);
`ifdef WB_FWD_EN
      chk("fwd_hit1", bus.fwd_hit1, m_we && (m_waddr == bus.fwd_raddr1) && (m_waddr != 0));
      chk("fwd_hit2", bus.fwd_hit2, m_we && (m_waddr == bus.fwd_raddr2) && (m_waddr != 0));
      chk("fwd_data", bus.fwd_data, m_wdata);
`endif
      if (bus.rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_order actual=write_to_0x%0h required=no_write t=%0t", bus.rf_waddr, $time);
        end else begin
          front = exp_q.pop_front();
          chk("wb_order", {bus.rf_waddr, bus.rf_wdata}, front);
        end
      end
      // model advance for the coming posedge (inputs are stable until then)
      if (rst) begin
        m_ptr   = 0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_busy  = '0;
        exp_q.delete();
      end else begin
        if (g >= 0) begin
          a       = AW'(bus.req_addr >> (g * AW));
          d       = DW'(bus.req_data >> (g * DW));
          m_ptr   = (g + 1) % NREQ;
          m_we    = (a != 0);
          m_waddr = a;
          m_wdata = d;
          if (a != 0) begin
            exp_q.push_back({a, d});
            m_busy[a] = 1'b0;
          end
        end else begin
          m_we = 1'b0;
        end
        if (bus.iss_vld && (bus.iss_addr != 0)) m_busy[bus.iss_addr] = 1'b1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [NREQ-1:0] mix_vld [12] = '{3'b011, 3'b110, 3'b101, 3'b111, 3'b010, 3'b000,
                                    3'b100, 3'b111, 3'b001, 3'b011, 3'b111, 3'b110};

  initial begin
    rst = 1'b1;
    set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'hA000_0001, 32'hB000_0002, 32'hC000_0003);
    set_iss(1'b0, 5'd0);
`ifdef WB_FWD_EN
    bus.fwd_raddr1 = 5'd0;
    bus.fwd_raddr2 = 5'd0;
`endif

    // reset held with all requests valid
    mid();
    chk("rst_rdy",  bus.req_rdy, 3'b000);
    chk("rst_we",   bus.rf_we,   1'b0);
    chk("rst_busy", bus.busy,    32'h0);
    tick();
    mid();
    chk("rst_rdy2", bus.req_rdy, 3'b000);
    tick();
    rst = 1'b0;

    // round robin with all three valid for 6 cycles
    for (int i = 0; i < 6; i++) begin
      mid();
      chk("rr_grant", bus.req_rdy, 64'(1) << (i % 3));
      if (i > 0) begin
        chk("rr_we",    bus.rf_we,    1'b1);
        chk("rr_waddr", bus.rf_waddr, 64'((i - 1) % 3 + 1));
      end
      tick();
    end
    set_req(3'b000, 5'd1, 5'd2, 5'd3, 32'hA000_0001, 32'hB000_0002, 32'hC000_0003);
    mid();
    chk("rr_last_waddr", bus.rf_waddr, 5'd3);
    chk("rr_last_wdata", bus.rf_wdata, 32'hC000_0003);
    chk("rr_idle_rdy",   bus.req_rdy,  3'b000);

    // single write from requester 0
    tick();
    set_req(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    mid();
    chk("sw_rdy", bus.req_rdy, 3'b001);
    tick();
    set_req(3'b000, 5'd5, 5'd0, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    mid();
    chk("sw_we",    bus.rf_we,    1'b1);
    chk("sw_waddr", bus.rf_waddr, 5'd5);
    chk("sw_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
    tick();
    mid();
    chk("sw_we_off", bus.rf_we, 1'b0);

    // scoreboard: set, set-wins-over-clear, later clear
    tick();
    set_iss(1'b1, 5'd7);
    tick();
    set_iss(1'b1, 5'd7);
    set_req(3'b001, 5'd7, 5'd0, 5'd0, 32'h7777_0001, 32'h0, 32'h0);
    mid();
    chk("sb_set",     bus.busy,    32'h0000_0080);
    chk("sb_gnt_rdy", bus.req_rdy, 3'b001);
    tick();
    set_req(3'b000, 5'd7, 5'd0, 5'd0, 32'h7777_0001, 32'h0, 32'h0);
    set_iss(1'b1, 5'd12);
    mid();
    chk("sb_set_wins", bus.busy,     32'h0000_0080);
    chk("sb_wr_waddr", bus.rf_waddr, 5'd7);
    tick();
    set_iss(1'b0, 5'd0);
    set_req(3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h7000_0002);
    mid();
    chk("sb_two_set", bus.busy,    32'h0000_1080);
    chk("sb_rdy2",    bus.req_rdy, 3'b100);
    tick();
    set_req(3'b000, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h7000_0002);
    mid();
    chk("sb_clear", bus.busy,     32'h0000_1000);
    chk("sb_wdata", bus.rf_wdata, 32'h7000_0002);

    // register 0: consumed, no write, scoreboard untouched
    tick();
    set_req(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0000_1234, 32'h0);
    mid();
    chk("r0_rdy", bus.req_rdy, 3'b010);
    tick();
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0000_1234, 32'h0);
    mid();
    chk("r0_we",   bus.rf_we, 1'b0);
    chk("r0_busy", bus.busy,  32'h0000_1000);

    // reset in the cycle after a grant to register 9
    tick();
    set_req(3'b001, 5'd9, 5'd0, 5'd0, 32'h9999_0009, 32'h0, 32'h0);
`ifdef WB_FWD_EN
    bus.fwd_raddr1 = 5'd9;
    bus.fwd_raddr2 = 5'd4;
`endif
    mid();
    chk("rw_rdy", bus.req_rdy, 3'b001);
    tick();
    rst = 1'b1;
    set_req(3'b111, 5'd9, 5'd10, 5'd11, 32'h9999_0009, 32'h1, 32'h2);
    mid();
    chk("rw_we_pre",   bus.rf_we,   1'b1);
    chk("rw_rdy_rst",  bus.req_rdy, 3'b000);
`ifdef WB_FWD_EN
    chk("fwd_hit1_9",  bus.fwd_hit1, 1'b1);
    chk("fwd_hit2_4",  bus.fwd_hit2, 1'b0);
    chk("fwd_data_9",  bus.fwd_data, 32'h9999_0009);
`endif
    tick();
    rst = 1'b0;
    set_req(3'b000, 5'd9, 5'd10, 5'd11, 32'h9999_0009, 32'h1, 32'h2);
    mid();
    chk("rw_we_post", bus.rf_we, 1'b0);
    chk("rw_busy",    bus.busy,  32'h0);

    // write to register 0 with the bypass pointed at register 0
    tick();
    set_req(3'b001, 5'd0, 5'd0, 5'd0, 32'h0000_0055, 32'h0, 32'h0);
`ifdef WB_FWD_EN
    bus.fwd_raddr1 = 5'd0;
`endif
    tick();
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0000_0055, 32'h0, 32'h0);
    mid();
    chk("z_we", bus.rf_we, 1'b0);
`ifdef WB_FWD_EN
    chk("fwd_hit1_0", bus.fwd_hit1, 1'b0);
`endif

    // mixed request patterns with issues, checked by the model only
    for (int i = 0; i < 12; i++) begin
      tick();
      set_req(mix_vld[i], 5'd10, 5'd11, 5'd0, 32'h1010_1010, 32'h1111_1111, 32'h0000_2222);
      set_iss((i % 3) == 0, (i % 2) ? 5'd10 : 5'd20);
    end
    tick();
    set_req(3'b000, 5'd10, 5'd11, 5'd0, 32'h1010_1010, 32'h1111_1111, 32'h0000_2222);
    set_iss(1'b0, 5'd0);
    tick();
    tick();
    mid();
    chk("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the single register-file write port among three writeback requesters: ALU, load unit and mul/div unit.
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered write outputs feed the register file's we/waddr/wdata, which the register file samples on negedge clk.
- A 32-entry pending-write scoreboard is maintained here so that issue logic can stall on registers that still have a write in flight.

Parameters:
- NREQ, 3, number of writeback requesters (0=ALU, 1=load, 2=mul/div).
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_vld  in  NREQ  per-requester write request valid.
- req_addr  in  NREQ*AW  packed destination addresses; requester i occupies bits [i*AW +: AW].
- req_data  in  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
- req_rdy  out  NREQ  one-hot grant; a transfer occurs when req_vld[i] & req_rdy[i].
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  AW  register-file write address (registered).
- rf_wdata  out  DW  register-file write data (registered).
- iss_vld  in  1  an instruction with a destination register issued this cycle.
- iss_addr  in  AW  that instruction's destination register.
- busy  out  32  scoreboard; bit k=1 means a write to register k is pending.

Behaviour:
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, round-robin pointer=0. req_rdy is 0 while rst is high.
- Arbitration is combinational from req_vld and the pointer.
  - Search starts at index ptr and wraps modulo NREQ.
  - The first asserted req_vld gets req_rdy.
  - At most one req_rdy bit is high. req_rdy=0 when no request is pending.
- Pointer update: on a granted transfer from index g, ptr <= (g+1) mod NREQ. With no grant, ptr holds.
- Write latency is 1 cycle. A grant in cycle t drives rf_we=1, rf_waddr=req_addr[g] and rf_wdata=req_data[g] during cycle t+1. With no grant, rf_we=0 next cycle and addr/data hold their previous values.
- Register 0:
  - A request to address 0 is still granted and consumed (req_rdy=1), so the requester is not stalled.
  - rf_we stays 0 for it, and the scoreboard bit is not touched.
- Requesters must hold req_addr/req_data stable while req_vld=1 and not granted. The arbiter does not require that req_vld stay asserted.
- Scoreboard rules:
  - Set: iss_vld=1 and iss_addr!=0 -> busy[iss_addr] <= 1.
  - Clear: a granted transfer to addr a!=0 -> busy[a] <= 0, in the grant cycle, so the clear is visible together with the rf_we cycle.
  - Simultaneous set and clear of the same address: set wins, because the issue belongs to a newer producer.
  - Simultaneous set and clear of different addresses: both take effect.
  - busy[0] is always 0.
- Reset mid-operation: a pending grant is discarded, rf_we=0 on the next cycle, and the scoreboard is cleared. Requesters must re-present after reset.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,0,... Every valid requester is served within NREQ cycles.

Optional Feature:
WB_FWD_EN
- Defined: adds inputs fwd_raddr1 and fwd_raddr2 (AW each) and outputs fwd_hit1, fwd_hit2 (1 each) and fwd_data (DW).
  - fwd_hitN = rf_we & (rf_waddr==fwd_raddrN) & (rf_waddr!=0), combinational.
  - fwd_data = rf_wdata.
  - Lets decode bypass the register file in the writeback cycle.
- Undefined: these ports do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset check: hold rst for 2 cycles with all req_vld=1 -> req_rdy=000, rf_we=0, busy=0; the first grant after release goes to requester 0.
- Single write: req_vld=001, addr=5, data=0xDEADBEEF -> req_rdy=001 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; the cycle after, rf_we=0.
- Round robin: req_vld=111 held for 6 cycles with distinct addrs 1/2/3 -> grant order 0,1,2,0,1,2; rf_waddr sequence 1,2,3,1,2,3 delayed by one cycle.
- Register 0: requester 1 writes addr 0, data 0x1234 -> req_rdy[1]=1, rf_we stays 0, busy unchanged.
- Scoreboard: issue addr 7 -> busy[7]=1; next cycle, grant a write to 7 while iss_vld=1 with iss_addr=7 -> busy[7] stays 1; a later write to 7 with no issue -> busy[7]=0.
- Reset during write (plus WB_FWD_EN build): grant addr 9, assert rst in the next cycle -> rf_we=0 after reset and busy=0. With the macro defined, a write to 9 with fwd_raddr1=9 gives fwd_hit1=1 and fwd_data equal to the written data; fwd_raddr1=0 with a write to 0 gives fwd_hit1=0.
